// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch stage: next-PC select codes (also used
// by the decoder), fetch FSM states and the default reset PC.
package ifu_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'd0,
        NPC_BEQ  = 2'd1,
        NPC_JUMP = 2'd2,
        NPC_JR   = 2'd3
    } npc_sel_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC calculator: sequential, beq, j/jal and jr targets.
// All arithmetic is modulo 2^ADDR_W.
module ifu_npc
    import ifu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       instr_index,
    input  logic [1:0]        choose_way,
    input  logic              zero,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] br_off;

    assign pc_plus4 = pc + ADDR_W'(4);
    // Branch offset is a signed word count relative to the delay-slot-free pc+4.
    assign br_off   = {{(ADDR_W-18){instr_index[15]}}, instr_index[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel_e'(choose_way))
            NPC_SEQ:  next_pc = pc_plus4;
            NPC_BEQ:  if (zero) next_pc = pc_plus4 + br_off;
            NPC_JUMP: next_pc = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00};
            NPC_JR:   next_pc = rs_data[ADDR_W-1:0];
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch / next-PC stage: owns the PC, fetches one word at a time and
// holds it for the decoder until retired. IFU_ALIGN_CHECK_EN adds align_err/FAULT.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              reset,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_gnt,
    input  logic              im_rvalid,
    input  logic [31:0]       im_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic [1:0]        choose_way,
    input  logic              zero,
    input  logic [31:0]       rs_data,
    output logic [31:0]       fetch_cnt
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    // Handshakes: a request is accepted on an edge where im_req && im_gnt; data is
    // taken on an edge in WAIT where im_rvalid is high (ignored in any other state);
    // the decoder retires on an edge where instr_valid && instr_ack.
    fetch_state_e      state_q, state_d;
    logic              load_instr;
    logic              retire;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_load;
`ifdef IFU_ALIGN_CHECK_EN
    logic              fault;
`endif

    ifu_npc #(.ADDR_W(ADDR_W)) u_npc (
        .pc          (pc),
        .instr_index (instr[25:0]),
        .choose_way  (choose_way),
        .zero        (zero),
        .rs_data     (rs_data),
        .next_pc     (next_pc),
        .pc_plus4    (pc_plus4)
    );

    assign im_addr = pc;

`ifdef IFU_ALIGN_CHECK_EN
    assign pc_load = next_pc;
`else
    // Without the checker a misaligned target is silently word-aligned.
    assign pc_load = next_pc & ~ADDR_W'(3);
`endif

    always_comb begin
        state_d    = state_q;
        im_req     = 1'b0;
        load_instr = 1'b0;
        retire     = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        fault      = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                im_req = 1'b1;
                if (im_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    load_instr = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ack) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        fault   = 1'b1;
                        state_d = S_FAULT;
                    end else
`endif
                    begin
                        retire  = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc          <= PC_RESET;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (load_instr) begin
                instr       <= im_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= pc_load;
                instr_valid <= 1'b0;
                fetch_cnt   <= fetch_cnt + 32'd1;
            end
`ifdef IFU_ALIGN_CHECK_EN
            if (fault) instr_valid <= 1'b0;
`endif
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_err <= 1'b0;
        end else if (fault) begin
            align_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch and next-PC stage directly upstream of the main decoder.
- Owns the PC register and fetches words from instruction memory over a req/gnt/rvalid handshake.
- Presents the instruction (opcode [31:26], funct [5:0]) to the decoder.
- Computes the next PC from the decoder's 2-bit next-PC select, the ALU zero flag and the rs value.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC and im_addr width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- im_req  out  1  fetch request to instruction memory
- im_addr  out  ADDR_W  byte address of the fetch; equals pc
- im_gnt  in  1  memory accepts the request this cycle
- im_rvalid  in  1  im_rdata valid this cycle
- im_rdata  in  32  fetched word
- instr  out  32  current instruction to the decoder
- instr_valid  out  1  instr is valid and awaiting retirement
- instr_ack  in  1  core retires the current instruction this cycle
- pc  out  ADDR_W  address of the current instruction
- pc_plus4  out  ADDR_W  pc+4; jal link value
- choose_way  in  2  next-PC select: 0 sequential, 1 beq, 2 j/jal, 3 jr
- zero  in  1  ALU equality flag for beq
- rs_data  in  32  GPR[rs]; jr target
- fetch_cnt  out  32  count of retired instructions

Behaviour:
- Reset, asynchronous, applies immediately:
  - pc=PC_RESET, instr=0, instr_valid=0, im_req=0, fetch_cnt=0, state=IDLE.
  - Any in-flight memory response is discarded.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: im_req=0. Moves to REQ on the first clk edge after reset deasserts.
  - REQ: im_req=1, im_addr=pc. If im_gnt=1 -> WAIT; otherwise stay in REQ, holding im_addr stable.
  - WAIT: im_req=0. If im_rvalid=1: latch instr=im_rdata, set instr_valid=1, -> HOLD. Otherwise stay.
  - HOLD: instr and pc held stable. If instr_ack=1 on an edge: pc<=next_pc, instr_valid<=0, fetch_cnt++, -> REQ.
- Single-stage processing: at most one request outstanding.
- im_rvalid is ignored outside WAIT.
- im_gnt and im_rvalid asserted in the same cycle while in REQ: grant is taken, data is ignored. The memory must return data no earlier than the cycle after the grant.
- Minimum latency from REQ entry to instr_valid: 2 cycles (gnt in REQ, rvalid in the next cycle).
- next_pc, combinational, sampled only on the ack edge:
  - 0: pc+4.
  - 1: if zero=1, pc+4 + (sign-extended instr[15:0] << 2); else pc+4.
  - 2: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 3: rs_data.
- No branch delay slot.
- All adds are modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- choose_way, zero and rs_data are don't-care while instr_valid=0.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - Adds output port align_err (1 bit, reset 0).
  - If next_pc[1:0]!=0 on an ack edge: pc is not updated, align_err<=1, FSM enters a terminal state FAULT (im_req=0, instr_valid=0).
  - Only reset leaves FAULT.
- Undefined:
  - No align_err port.
  - Bits [1:0] of next_pc are forced to 00 before loading into pc.

Decomposition:
- Package ifu_pkg holds:
  - next-PC select enum: NPC_SEQ=0, NPC_BEQ=1, NPC_JUMP=2, NPC_JR=3.
  - FSM state typedef.
  - PC_RESET default constant.
- The decoder imports the same NPC_* constants.
- One sub-module: ifu_npc, a purely combinational next_pc/pc_plus4 calculator (pc, instr, choose_way, zero, rs_data -> next_pc, pc_plus4).
- The FSM, PC register and counter stay in ifu_fetch.

Test Plan:
- Reset release, memory grants immediately and returns 32'h3408_0001 one cycle later -> im_addr=32'h3000; instr_valid rises 2 cycles after REQ entry; pc=32'h3000; pc_plus4=32'h3004.
- Sequential ack with choose_way=0 -> next im_addr=32'h3004; fetch_cnt=1.
- beq, instr[15:0]=16'hFFFF at pc=32'h3010:
  - zero=1 -> pc becomes 32'h3010.
  - zero=0 -> pc becomes 32'h3014.
- jal, instr[25:0]=26'h0000C10, choose_way=2 -> pc=32'h0000_3040; pc_plus4 before ack equals link value pc+4.
- im_gnt held low 5 cycles, then rvalid delayed 3 cycles, reset pulsed during WAIT -> im_addr stable throughout; after reset pc=32'h3000, instr_valid=0, fetch_cnt=0; late rvalid ignored.
- jr with rs_data=32'h0000_3002:
  - IFU_ALIGN_CHECK_EN defined -> align_err=1, im_req stays 0.
  - Undefined -> pc=32'h3000.
